// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit:
// funct3 encodings, FSM state type and operand signedness helpers.
package muldiv_pkg;

  localparam logic [2:0] FUNCT3_MUL    = 3'd0;
  localparam logic [2:0] FUNCT3_MULH   = 3'd1;
  localparam logic [2:0] FUNCT3_MULHSU = 3'd2;
  localparam logic [2:0] FUNCT3_MULHU  = 3'd3;
  localparam logic [2:0] FUNCT3_DIV    = 3'd4;
  localparam logic [2:0] FUNCT3_DIVU   = 3'd5;
  localparam logic [2:0] FUNCT3_REM    = 3'd6;
  localparam logic [2:0] FUNCT3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  function automatic logic is_div(input logic [2:0] f);
    return f[2];
  endfunction

  function automatic logic is_signed_rs1(input logic [2:0] f);
    return (f == FUNCT3_MUL) || (f == FUNCT3_MULH) || (f == FUNCT3_MULHSU) ||
           (f == FUNCT3_DIV) || (f == FUNCT3_REM);
  endfunction

  function automatic logic is_signed_rs2(input logic [2:0] f);
    return (f == FUNCT3_MUL) || (f == FUNCT3_MULH) ||
           (f == FUNCT3_DIV) || (f == FUNCT3_REM);
  endfunction

endpackage

// File: rtl/muldiv_operand_prep.sv
// Combinational operand conditioning: magnitudes, result signs and
// detection of the divide-by-zero and signed-overflow special cases.
module muldiv_operand_prep
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_operand_1,
  input  logic [XLEN-1:0] i_operand_2,
  output logic [XLEN-1:0] o_abs_1,
  output logic [XLEN-1:0] o_abs_2,
  output logic            o_neg_result,
  output logic            o_neg_remainder,
  output logic            o_div_by_zero,
  output logic            o_overflow
);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic w_sign_1;
  logic w_sign_2;

  assign w_sign_1        = is_signed_rs1(i_funct3) & i_operand_1[XLEN-1];
  assign w_sign_2        = is_signed_rs2(i_funct3) & i_operand_2[XLEN-1];
  assign o_abs_1         = w_sign_1 ? -i_operand_1 : i_operand_1;
  assign o_abs_2         = w_sign_2 ? -i_operand_2 : i_operand_2;
  assign o_neg_result    = w_sign_1 ^ w_sign_2;
  assign o_neg_remainder = w_sign_1;
  assign o_div_by_zero   = (i_operand_2 == '0);
  assign o_overflow      = is_div(i_funct3) && is_signed_rs2(i_funct3) &&
                           (i_operand_1 == MOST_NEG) && (i_operand_2 == '1);

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle shift-add multiply
// and restoring divide, fixed XLEN+2 cycle latency, start/busy/done handshake.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_1,
  input  logic [XLEN-1:0] operand_2,
  input  logic [4:0]      dest_register_select,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      write_register_select
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t r_state, w_next_state;

  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_hi, r_lo, r_b, r_op1, r_result;
  logic [2:0]      r_funct3;
  logic [4:0]      r_rd, r_wrs;
  logic            r_neg_res, r_neg_rem, r_dbz, r_ovf, r_done;

  logic [XLEN-1:0] w_abs_1, w_abs_2;
  logic            w_neg_res, w_neg_rem, w_dbz, w_ovf;

  muldiv_operand_prep #(.XLEN(XLEN)) u_prep (
    .i_funct3       (funct3),
    .i_operand_1    (operand_1),
    .i_operand_2    (operand_2),
    .o_abs_1        (w_abs_1),
    .o_abs_2        (w_abs_2),
    .o_neg_result   (w_neg_res),
    .o_neg_remainder(w_neg_rem),
    .o_div_by_zero  (w_dbz),
    .o_overflow     (w_ovf)
  );

  // r_hi/r_lo are shared: product accumulator/multiplier for MUL*, remainder/quotient for DIV*
  logic [XLEN:0]   w_mul_sum, w_div_shift, w_div_diff;
  logic [XLEN-1:0] w_hi_next, w_lo_next;

  always_comb begin
    w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_div_shift = {r_hi, r_lo[XLEN-1]};
    w_div_diff  = w_div_shift - {1'b0, r_b};
    w_hi_next   = w_mul_sum[XLEN:1];
    w_lo_next   = {w_mul_sum[0], r_lo[XLEN-1:1]};
    if (is_div(r_funct3)) begin
      if (!w_div_diff[XLEN]) begin
        w_hi_next = w_div_diff[XLEN-1:0];
        w_lo_next = {r_lo[XLEN-2:0], 1'b1};
      end else begin
        w_hi_next = w_div_shift[XLEN-1:0];
        w_lo_next = {r_lo[XLEN-2:0], 1'b0};
      end
    end
  end

  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_final;

  always_comb begin
    w_prod = r_neg_res ? -{r_hi, r_lo} : {r_hi, r_lo};
    w_quo  = r_neg_res ? -r_lo : r_lo;
    w_rem  = r_neg_rem ? -r_hi : r_hi;
    if (r_dbz) begin
      w_quo = '1;
      w_rem = r_op1;
    end
    if (r_ovf) begin
      w_quo = MOST_NEG;
      w_rem = '0;
    end
    case (r_funct3)
      FUNCT3_MUL:                               w_final = w_prod[XLEN-1:0];
      FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
      FUNCT3_DIV, FUNCT3_DIVU:                  w_final = w_quo;
      default:                                  w_final = w_rem;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next_state = ST_CALC;
      ST_CALC:   if (r_count == CW'(XLEN-1)) w_next_state = ST_FINISH;
      ST_FINISH: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_done    <= 1'b0;
      r_result  <= '0;
      r_wrs     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_b       <= '0;
      r_op1     <= '0;
      r_funct3  <= '0;
      r_rd      <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_dbz     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_count   <= '0;
            r_hi      <= '0;
            r_lo      <= is_div(funct3) ? w_abs_1 : w_abs_2;
            r_b       <= is_div(funct3) ? w_abs_2 : w_abs_1;
            r_op1     <= operand_1;
            r_funct3  <= funct3;
            r_rd      <= dest_register_select;
            r_neg_res <= w_neg_res;
            r_neg_rem <= w_neg_rem;
            r_dbz     <= w_dbz;
            r_ovf     <= w_ovf;
          end
        end
        ST_CALC: begin
          r_count <= r_count + 1'b1;
          r_hi    <= w_hi_next;
          r_lo    <= w_lo_next;
        end
        ST_FINISH: begin
          r_result <= w_final;
          r_wrs    <= r_rd;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy                  = (r_state != ST_IDLE);
  assign done                  = r_done;
  assign result                = r_result;
  assign write_register_select = r_wrs;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against a 64-bit arithmetic
// reference of the RV32M rules, including latency, handshake and reset abort.
module tb_muldiv_unit;

  logic        clk, reset_n, start;
  logic [2:0]  funct3;
  logic [31:0] operand_1, operand_2;
  logic [4:0]  dest_register_select;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  write_register_select;

  int n_vec = 0;
  int n_err = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .start                (start),
    .funct3               (funct3),
    .operand_1            (operand_1),
    .operand_2            (operand_2),
    .dest_register_select (dest_register_select),
    .busy                 (busy),
    .done                 (done),
    .result               (result),
    .write_register_select(write_register_select)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] ref_model(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    logic [63:0] p;
    case (f)
      3'd0: p = sa * sb;
      3'd1: begin p = sa * sb; p = p >> 32; end
      3'd2: begin p = sa * ub; p = p >> 32; end
      3'd3: begin p = ua * ub; p = p >> 32; end
      3'd4: if (b == 0) p = '1; else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'b0, a}; else p = sa / sb;
      3'd5: if (b == 0) p = '1; else p = ua / ub;
      3'd6: if (b == 0) p = {32'b0, a}; else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = 0; else p = sa % sb;
      default: if (b == 0) p = {32'b0, a}; else p = ua % ub;
    endcase
    return p[31:0];
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(logic [2:0] f, logic [31:0] a, logic [31:0] b, logic [4:0] rd);
    funct3 = f; operand_1 = a; operand_2 = b; dest_register_select = rd;
    start = 1'b1;
  endtask

  // Call with start already high; returns at the sample where done is seen.
  task automatic wait_done(string tag, logic [31:0] exp, logic [4:0] exp_rd, int poke_at);
    int lat;
    @(posedge clk); #1;
    start = 1'b0;
    operand_1 = $urandom; operand_2 = $urandom;
    funct3 = 3'($urandom); dest_register_select = 5'($urandom);
    chk({tag, "_busy"}, busy, 1);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      start = (lat == poke_at);
      if (start) begin
        operand_1 = $urandom; operand_2 = $urandom;
        funct3 = 3'($urandom); dest_register_select = 5'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, lat, 33);
    chk({tag, "_result"}, result, exp);
    chk({tag, "_rd"}, write_register_select, exp_rd);
  endtask

  task automatic post_check(string tag, logic [31:0] exp, logic [4:0] exp_rd);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {busy, done}, 2'b00);
    chk({tag, "_held"}, {write_register_select, result}, {exp_rd, exp});
  endtask

  task automatic run(string tag, logic [2:0] f, logic [31:0] a, logic [31:0] b,
                     logic [4:0] rd, logic [31:0] exp, int poke_at);
    @(negedge clk);
    issue(f, a, b, rd);
    wait_done(tag, exp, rd, poke_at);
    post_check(tag, exp, rd);
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic        seen;

    reset_n = 1'b0; start = 1'b0; funct3 = '0;
    operand_1 = '0; operand_2 = '0; dest_register_select = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {busy, done, write_register_select, result}, '0);
    @(negedge clk);
    reset_n = 1'b1;

    run("mul",     3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, -1);
    run("mulh",    3'd1, 32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000, -1);
    run("mulhu",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, -1);
    run("mulhsu",  3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, -1);
    run("div",     3'd4, 32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFD, -1);
    run("rem",     3'd6, 32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFF, -1);
    run("divu",    3'd5, 32'd100,        32'd7,         5'd11, 32'd14,        -1);
    run("remu",    3'd7, 32'd100,        32'd7,         5'd12, 32'd2,         -1);
    run("divu_z",  3'd5, 32'd5,          32'd0,         5'd13, 32'hFFFF_FFFF, -1);
    run("remu_z",  3'd7, 32'd5,          32'd0,         5'd14, 32'd5,         -1);
    run("div_z",   3'd4, 32'hFFFF_FFF9,  32'd0,         5'd15, 32'hFFFF_FFFF, -1);
    run("rem_z",   3'd6, 32'hFFFF_FFF9,  32'd0,         5'd16, 32'hFFFF_FFF9, -1);
    run("div_ovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd17, 32'h8000_0000, -1);
    run("rem_ovf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd18, 32'd0,         -1);
    run("poke",    3'd0, 32'd7,          32'hFFFF_FFFD, 5'd19, 32'hFFFF_FFEB, 5);

    // start held high in the done cycle is accepted immediately
    @(negedge clk);
    issue(3'd5, 32'd100, 32'd7, 5'd3);
    wait_done("b2b_first", 32'd14, 5'd3, -1);
    issue(3'd7, 32'd100, 32'd7, 5'd4);
    wait_done("b2b_second", 32'd2, 5'd4, -1);
    post_check("b2b_second", 32'd2, 5'd4);

    // reset during iteration 10 discards the operation
    @(negedge clk);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_reset", {busy, done, write_register_select, result}, '0);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    chk("abort_no_done", seen, 0);
    run("after_abort", 3'd6, 32'd100, 32'd7, 5'd21, 32'd2, -1);

    for (int i = 0; i < 40; i++) begin
      f  = 3'($urandom_range(0, 7));
      rd = 5'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
        3: b = $urandom_range(0, 15) - 7;
        default: ;
      endcase
      run($sformatf("rand%0d_f%0d", i, f), f, a, b, rd, ref_model(f, a, b), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
